// File: rtl/vga_multi_image_compositor.sv
// vga_multi_image_compositor
//
// Generates 640x480 VGA timing from the 50 MHz system clock using a pixel-tick
// enable (every second clock). It reads NUM_IMG synchronous grayscale image
// memories and places the images side by side, left to right, on a background
// colour. The display mode is latched only at frame start, so a mode change
// never tears a frame.
//
// Ports
//   clk_50Mhz_in  system clock
//   reset         synchronous, active-high
//   mode          0 gray, 1 invert, 2 threshold, 3 gray with 1-pixel white border
//   threshold     level used by mode 2 (latched together with mode)
//   img_en        per-window enable; a disabled window shows BG_COLOR
//   img_adr       read address per image, slice k = image k
//   img_data      read data per image (32 bits each), valid 2 clocks after address
//   VGA_HS/VS     active-low syncs
//   VGA_R/G/B     colour
//   VGA_BLANK_N   high inside the active area
//   VGA_SYNC_N    constant 0
//   VGA_CLK       25 MHz pixel clock (the tick phase register)
//   frame_start   one-clock pulse when the counters enter (0,0)
module vga_multi_image_compositor #(
    parameter int NUM_IMG  = 2,
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int ADR_W    = 16,
    parameter int PIX_W    = 8,
    parameter int X0       = 32,
    parameter int Y0       = 112,
    parameter int GAP      = 32,
    parameter int H_ACT    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACT    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic                     clk_50Mhz_in,
    input  logic                     reset,
    input  logic [1:0]               mode,
    input  logic [7:0]               threshold,
    input  logic [NUM_IMG-1:0]       img_en,
    output logic [NUM_IMG*ADR_W-1:0] img_adr,
    input  logic [NUM_IMG*32-1:0]    img_data,
    output logic                     VGA_HS,
    output logic                     VGA_VS,
    output logic [7:0]               VGA_R,
    output logic [7:0]               VGA_G,
    output logic [7:0]               VGA_B,
    output logic                     VGA_BLANK_N,
    output logic                     VGA_SYNC_N,
    output logic                     VGA_CLK,
    output logic                     frame_start
);

    localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = $clog2(IMG_W);
    localparam int YW      = $clog2(IMG_H);
    localparam int IW      = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1;

    logic          phase;
    logic          tick;
    logic [HW-1:0] h_cnt, h_nxt;
    logic [VW-1:0] v_cnt, v_nxt;
    logic          frame_wrap;
    logic [1:0]    mode_q;
    logic [7:0]    thr_q;

    // Stage 0 decode, evaluated on the counter values being entered this tick
    logic [31:0]          hx, vy;
    logic                 in_y;
    logic [YW-1:0]        loc_y;
    logic [NUM_IMG-1:0]   in_x;
    logic [XW-1:0]        loc_x [NUM_IMG];
    logic                 hit;
    logic [IW-1:0]        hit_idx;
    logic                 border;
    logic                 active, hs_raw, vs_raw;

    // Pipeline registers
    logic          s0_active, s0_hs, s0_vs, s0_hit, s0_border;
    logic [IW-1:0] s0_idx;
    logic          s1_active, s1_hs, s1_vs, s1_hit, s1_border;
    logic [7:0]    s1_pix;

    logic [31:0]        sel_word;
    logic [PIX_W+7:0]   pix_ext;
    logic [7:0]         pix_aligned;
    logic [23:0]        rgb_nxt;
    logic               unused_bits;

    assign tick       = phase;
    assign VGA_CLK    = phase;
    assign VGA_SYNC_N = 1'b0;

    // Next counter position. Stage 0 works on this value so that the outputs
    // for a position appear two ticks after the counters enter it.
    always_comb begin
        h_nxt      = h_cnt + 1'b1;
        v_nxt      = v_cnt;
        frame_wrap = 1'b0;
        if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_nxt = '0;
            if (v_cnt == VW'(V_TOTAL - 1)) begin
                v_nxt      = '0;
                frame_wrap = 1'b1;
            end else begin
                v_nxt = v_cnt + 1'b1;
            end
        end
    end

    // Window hit, local coordinates, border flag, active area and raw syncs.
    // Windows never overlap, so at most one of them matches.
    always_comb begin
        hx      = 32'(h_nxt);
        vy      = 32'(v_nxt);
        in_y    = (vy >= Y0) && (vy < Y0 + IMG_H);
        loc_y   = YW'(vy - Y0);
        hit     = 1'b0;
        hit_idx = '0;
        border  = 1'b0;
        for (int k = 0; k < NUM_IMG; k++) begin
            in_x[k]  = (hx >= X0 + k * (IMG_W + GAP)) && (hx < X0 + k * (IMG_W + GAP) + IMG_W);
            loc_x[k] = XW'(hx - (X0 + k * (IMG_W + GAP)));
            if (in_x[k] && in_y) begin
                hit     = img_en[k];
                hit_idx = IW'(k);
                border  = (loc_x[k] == '0) || (loc_x[k] == XW'(IMG_W - 1)) ||
                          (loc_y == '0) || (loc_y == YW'(IMG_H - 1));
            end
        end
        active = (hx < H_ACT) && (vy < V_ACT);
        hs_raw = !((hx >= H_ACT + H_FP) && (hx < H_ACT + H_FP + H_SYNC));
        vs_raw = !((vy >= V_ACT + V_FP) && (vy < V_ACT + V_FP + V_SYNC));
    end

    // Tick phase, position counters, frame_start pulse and the mode latch.
    // Mode and threshold are captured on the same clock that enters (0,0).
    always_ff @(posedge clk_50Mhz_in) begin
        if (reset) begin
            phase       <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
            mode_q      <= 2'd0;
            thr_q       <= 8'h80;
        end else begin
            phase       <= ~phase;
            frame_start <= 1'b0;
            if (tick) begin
                h_cnt <= h_nxt;
                v_cnt <= v_nxt;
                if (frame_wrap) begin
                    frame_start <= 1'b1;
                    mode_q      <= mode;
                    thr_q       <= threshold;
                end
            end
        end
    end

    // Stage 0: image addresses are {local_y, local_x}; an address only moves
    // while its window is being scanned, otherwise it holds.
    always_ff @(posedge clk_50Mhz_in) begin
        if (reset) begin
            img_adr   <= '0;
            s0_active <= 1'b0;
            s0_hs     <= 1'b1;
            s0_vs     <= 1'b1;
            s0_hit    <= 1'b0;
            s0_border <= 1'b0;
            s0_idx    <= '0;
        end else if (tick) begin
            for (int k = 0; k < NUM_IMG; k++) begin
                if (in_x[k] && in_y) begin
                    img_adr[k*ADR_W +: ADR_W] <= ADR_W'({loc_y, loc_x[k]});
                end
            end
            s0_active <= active;
            s0_hs     <= hs_raw;
            s0_vs     <= vs_raw;
            s0_hit    <= hit;
            s0_border <= border;
            s0_idx    <= hit_idx;
        end
    end

    // Select the hit window's memory word and left-align its pixel bits.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_IMG; k++) begin
            if (s0_idx == IW'(k)) begin
                sel_word = img_data[k*32 +: 32];
            end
        end
        pix_ext     = {sel_word[PIX_W-1:0], 8'h00};
        pix_aligned = pix_ext[PIX_W+7 -: 8];
        unused_bits = ^sel_word[31:PIX_W];
    end

    // Stage 1: sample the returned pixel, one tick after its address was set.
    always_ff @(posedge clk_50Mhz_in) begin
        if (reset) begin
            s1_active <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
            s1_hit    <= 1'b0;
            s1_border <= 1'b0;
            s1_pix    <= 8'h00;
        end else if (tick) begin
            s1_active <= s0_active;
            s1_hs     <= s0_hs;
            s1_vs     <= s0_vs;
            s1_hit    <= s0_hit;
            s1_border <= s0_border;
            s1_pix    <= pix_aligned;
        end
    end

    // Colour for the latched mode; zero outside the active area, background
    // outside the windows (or inside a disabled one).
    always_comb begin
        rgb_nxt = 24'h000000;
        if (s1_active) begin
            if (!s1_hit) begin
                rgb_nxt = BG_COLOR;
            end else begin
                case (mode_q)
                    2'd0:    rgb_nxt = {s1_pix, s1_pix, s1_pix};
                    2'd1:    rgb_nxt = {~s1_pix, ~s1_pix, ~s1_pix};
                    2'd2:    rgb_nxt = (s1_pix >= thr_q) ? 24'hFFFFFF : 24'h000000;
                    default: rgb_nxt = s1_border ? 24'hFFFFFF : {s1_pix, s1_pix, s1_pix};
                endcase
            end
        end
    end

    // Stage 2: output registers, so syncs, blank and colour share one depth.
    always_ff @(posedge clk_50Mhz_in) begin
        if (reset) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= 8'h00;
            VGA_G       <= 8'h00;
            VGA_B       <= 8'h00;
        end else if (tick) begin
            VGA_HS      <= s1_hs;
            VGA_VS      <= s1_vs;
            VGA_BLANK_N <= s1_active;
            VGA_R       <= rgb_nxt[23:16];
            VGA_G       <= rgb_nxt[15:8];
            VGA_B       <= rgb_nxt[7:0];
        end
    end

endmodule

// File: tb/tb_vga_multi_image_compositor.sv
// tb_vga_multi_image_compositor
//
// Directed bench for vga_multi_image_compositor. The DUT is built with a
// scaled-down raster (64x20 total, 48x14 active) and three 16x8 windows so
// that several whole frames fit in a short run:
//   window 0: h 4..19, window 1: h 24..39, window 2: h 44..59 (clipped at 48),
//   all windows v 2..9. HS low for h 52..59, VS low for v 16..17.
// Memory models: image 0 returns addr[7:0], image 1 returns 8'h40, image 2
// returns 8'hC0; upper word bits carry junk that must be ignored.
// Output for position (h,v) is expected fs_edge + 2*(v*64+h) + 4 clocks after
// the edge that raised frame_start.
module tb_vga_multi_image_compositor;

    localparam int HT        = 64;
    localparam int FRAME_CLK = 2 * 64 * 20;

    logic        clk_50Mhz_in = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic [7:0]  threshold;
    logic [2:0]  img_en;
    logic [47:0] img_adr;
    logic [95:0] img_data;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start;
    logic [7:0]  VGA_R, VGA_G, VGA_B;

    logic [31:0] mem_q0, mem_q1, mem_q2;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    int fs_edge  = 0;
    int prev_fs  = 0;
    int rel_cyc  = 0;
    logic found;

    vga_multi_image_compositor #(
        .NUM_IMG(3), .IMG_W(16), .IMG_H(8), .ADR_W(16), .PIX_W(8),
        .X0(4), .Y0(2), .GAP(4),
        .H_ACT(48), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACT(14), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .BG_COLOR(24'h203040)
    ) dut (
        .clk_50Mhz_in(clk_50Mhz_in),
        .reset(reset),
        .mode(mode),
        .threshold(threshold),
        .img_en(img_en),
        .img_adr(img_adr),
        .img_data(img_data),
        .VGA_HS(VGA_HS),
        .VGA_VS(VGA_VS),
        .VGA_R(VGA_R),
        .VGA_G(VGA_G),
        .VGA_B(VGA_B),
        .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N(VGA_SYNC_N),
        .VGA_CLK(VGA_CLK),
        .frame_start(frame_start)
    );

    always #10 clk_50Mhz_in = ~clk_50Mhz_in;

    always @(posedge clk_50Mhz_in) cyc <= cyc + 1;

    // Synchronous image memories
    always @(posedge clk_50Mhz_in) begin
        mem_q0 <= {24'hABCDEF, img_adr[7:0]};
        mem_q1 <= {24'h123456, 8'h40};
        mem_q2 <= {24'h0F0F0F, 8'hC0};
    end
    assign img_data = {mem_q2, mem_q1, mem_q0};

    task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cyc=%0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [7:0] t, input logic [2:0] en);
        mode      = m;
        threshold = t;
        img_en    = en;
    endtask

    task automatic waitCycle(input int target);
        while (cyc < target) @(negedge clk_50Mhz_in);
    endtask

    task automatic waitFrameStart(input int limit);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk_50Mhz_in);
            if (frame_start === 1'b1) begin
                found   = 1'b1;
                fs_edge = cyc;
            end
        end
        checkOutput("frame_start_seen", 48'(found), 48'd1);
    endtask

    function automatic int outCyc(input int h, input int v);
        return fs_edge + 2 * (v * HT + h) + 4;
    endfunction

    task automatic checkPixel(input string tag, input int h, input int v, input logic [23:0] exp);
        waitCycle(outCyc(h, v));
        checkOutput(tag, 48'({VGA_R, VGA_G, VGA_B}), 48'(exp));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_hs"},    48'(VGA_HS), 48'd1);
        checkOutput({tag, "_vs"},    48'(VGA_VS), 48'd1);
        checkOutput({tag, "_rgb"},   48'({VGA_R, VGA_G, VGA_B}), 48'd0);
        checkOutput({tag, "_blank"}, 48'(VGA_BLANK_N), 48'd0);
        checkOutput({tag, "_vgaclk"}, 48'(VGA_CLK), 48'd0);
        checkOutput({tag, "_fs"},    48'(frame_start), 48'd0);
        checkOutput({tag, "_adr"},   img_adr, 48'd0);
        checkOutput({tag, "_syncn"}, 48'(VGA_SYNC_N), 48'd0);
    endtask

    initial begin
        $display("[TB] start");
        reset = 1'b1;
        applyStimulus(2'd0, 8'h00, 3'b111);
        repeat (5) @(negedge clk_50Mhz_in);
        checkResetValues("por");
        reset = 1'b0;

        // ---------------- frame A: gray mode, timing ----------------
        waitFrameStart(6000);
        prev_fs = fs_edge;
        waitCycle(fs_edge + 1);
        checkOutput("fs_one_clock", 48'(frame_start), 48'd0);
        waitCycle(outCyc(0, 0));
        checkOutput("blank_0_0", 48'(VGA_BLANK_N), 48'd1);
        checkOutput("bg_0_0", 48'({VGA_R, VGA_G, VGA_B}), 48'h203040);
        waitCycle(outCyc(47, 0));
        checkOutput("blank_47", 48'(VGA_BLANK_N), 48'd1);
        waitCycle(outCyc(48, 0));
        checkOutput("blank_48", 48'(VGA_BLANK_N), 48'd0);
        waitCycle(outCyc(51, 0));
        checkOutput("hs_51", 48'(VGA_HS), 48'd1);
        waitCycle(outCyc(52, 0) - 1);
        checkOutput("hs_pre_fall", 48'(VGA_HS), 48'd1);
        waitCycle(outCyc(52, 0));
        checkOutput("hs_fall", 48'(VGA_HS), 48'd0);
        waitCycle(outCyc(59, 0));
        checkOutput("hs_59", 48'(VGA_HS), 48'd0);
        waitCycle(outCyc(60, 0));
        checkOutput("hs_rise", 48'(VGA_HS), 48'd1);

        checkPixel("a_bg_left",   3, 2, 24'h203040);
        checkPixel("a_w0_first",  4, 2, 24'h000000);
        checkPixel("a_w0_second", 5, 2, 24'h010101);
        checkPixel("a_w0_last",  19, 2, 24'h0F0F0F);
        checkPixel("a_gap",      20, 2, 24'h203040);
        checkPixel("a_w1_first", 24, 2, 24'h404040);
        checkPixel("a_w2_first", 44, 2, 24'hC0C0C0);
        checkPixel("a_w2_clip_in", 47, 2, 24'hC0C0C0);
        checkPixel("a_w2_clip_out", 48, 2, 24'h000000);
        checkOutput("a_clip_blank", 48'(VGA_BLANK_N), 48'd0);

        waitCycle(fs_edge + 2 * (5 * HT + 10) + 1);
        checkOutput("adr0_10_5", 48'(img_adr[15:0]), 48'd54);
        checkOutput("adr1_hold", 48'(img_adr[31:16]), 48'd47);

        checkPixel("a_p3f", 19, 5, 24'h3F3F3F);
        checkPixel("a_p40",  4, 6, 24'h404040);
        applyStimulus(2'd2, 8'h40, 3'b111);
        checkPixel("a_mode_held", 5, 7, 24'h515151);

        waitCycle(outCyc(0, 13));
        checkOutput("blank_v13", 48'(VGA_BLANK_N), 48'd1);
        waitCycle(outCyc(0, 14));
        checkOutput("blank_v14", 48'(VGA_BLANK_N), 48'd0);
        waitCycle(outCyc(63, 15));
        checkOutput("vs_v15", 48'(VGA_VS), 48'd1);
        waitCycle(outCyc(0, 16));
        checkOutput("vs_fall", 48'(VGA_VS), 48'd0);
        waitCycle(outCyc(63, 17));
        checkOutput("vs_v17", 48'(VGA_VS), 48'd0);
        waitCycle(outCyc(0, 18));
        checkOutput("vs_rise", 48'(VGA_VS), 48'd1);

        // ---------------- frame B: threshold mode ----------------
        waitFrameStart(3000);
        checkOutput("frame_len_a", 48'(fs_edge - prev_fs), 48'(FRAME_CLK));
        checkPixel("b_w1_eq_thr", 24, 2, 24'hFFFFFF);
        checkPixel("b_p3f", 19, 5, 24'h000000);
        checkPixel("b_p40",  4, 6, 24'hFFFFFF);
        checkPixel("b_p51",  5, 7, 24'hFFFFFF);
        applyStimulus(2'd1, 8'h40, 3'b111);
        waitCycle(fs_edge + FRAME_CLK - 1);
        applyStimulus(2'd3, 8'h40, 3'b111);
        prev_fs = fs_edge;

        // ---------------- frame C: border mode, enables, reset ----------------
        waitFrameStart(10);
        applyStimulus(2'd0, 8'h40, 3'b111);
        checkOutput("frame_len_b", 48'(fs_edge - prev_fs), 48'(FRAME_CLK));
        checkPixel("c_corner_tl",  4, 2, 24'hFFFFFF);
        checkPixel("c_inner",      5, 3, 24'h111111);
        checkPixel("c_w1_left",   24, 5, 24'hFFFFFF);
        checkPixel("c_w1_inner",  25, 5, 24'h404040);
        applyStimulus(2'd0, 8'h40, 3'b101);
        checkPixel("c_w0_still",   6, 8, 24'h626262);
        checkPixel("c_w1_disabled", 30, 8, 24'h203040);
        checkPixel("c_bottom",    10, 9, 24'hFFFFFF);
        checkPixel("c_corner_br", 19, 9, 24'hFFFFFF);

        reset = 1'b1;
        @(negedge clk_50Mhz_in);
        checkResetValues("mid");
        reset   = 1'b0;
        rel_cyc = cyc;
        for (int k = 1; k <= 6; k++) begin
            waitCycle(rel_cyc + k);
            checkOutput("vgaclk_toggle", 48'(VGA_CLK), 48'(k % 2));
            if (k == 4) begin
                checkOutput("no_stale_blank", 48'(VGA_BLANK_N), 48'd0);
                checkOutput("no_stale_rgb", 48'({VGA_R, VGA_G, VGA_B}), 48'd0);
            end
            if (k == 6) begin
                checkOutput("first_pix_blank", 48'(VGA_BLANK_N), 48'd1);
                checkOutput("first_pix_rgb", 48'({VGA_R, VGA_G, VGA_B}), 48'h203040);
            end
        end
        applyStimulus(2'd1, 8'h40, 3'b101);

        // ---------------- frame D: invert mode after reset ----------------
        waitFrameStart(3000);
        checkOutput("fs_after_reset", 48'(fs_edge - rel_cyc), 48'(FRAME_CLK));
        checkPixel("d_inv_w0", 5, 2, 24'hFEFEFE);
        checkPixel("d_w1_off", 24, 2, 24'h203040);
        checkPixel("d_inv_w2", 44, 2, 24'h3F3F3F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
